// File: rtl/fft_bitrev_streamer.sv
// fft_bitrev_streamer: ping-pong buffer that reorders 32-sample complex frames into bit-reversed order
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready, in_r/in_i     natural-order input stream
//   out_valid/out_ready, out_r/out_i bit-reversed output stream (zero when idle)
//   out_start/out_last               first/last sample of an output frame
//   ovf                              sticky: a sample was offered while the buffer was full
module fft_bitrev_streamer #(
    parameter int DATA_W = 16,
    parameter int N      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_i,
    output logic              out_start,
    output logic              out_last,
    output logic              ovf
);
    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
    logic [2*DATA_W-1:0] r_mem [2][N];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                r_ovf;
    logic [LOG2N-1:0]    r_wr_cnt;
    logic [LOG2N-1:0]    r_rd_cnt;
    logic [LOG2N-1:0]    w_rd_addr;
    logic                w_wr;
    logic                w_rd;
    logic                w_wr_done;
    logic                w_rd_done;
    logic [1:0]          w_set;
    logic [1:0]          w_clr;
    logic [2*DATA_W-1:0] w_rd_data;
    for (genvar b = 0; b < LOG2N; b++) begin : g_brev
        assign w_rd_addr[b] = r_rd_cnt[LOG2N-1-b];
    end
    assign in_ready  = !r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign w_wr      = in_valid && in_ready;
    assign w_rd      = out_valid && out_ready;
    assign w_wr_done = w_wr && (r_wr_cnt == LAST);
    assign w_rd_done = w_rd && (r_rd_cnt == LAST);
    // A completing write and a completing read always hit different banks, so both masks apply.
    assign w_set     = w_wr_done ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr     = w_rd_done ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_rd_data = r_mem[r_rd_bank][w_rd_addr];
    assign out_r     = out_valid ? w_rd_data[2*DATA_W-1:DATA_W] : '0;
    assign out_i     = out_valid ? w_rd_data[DATA_W-1:0] : '0;
    assign out_start = out_valid && (r_rd_cnt == '0);
    assign out_last  = out_valid && (r_rd_cnt == LAST);
    assign ovf       = r_ovf;
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_bank][r_wr_cnt] <= {in_r, in_i};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
            if (w_wr)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_wr_done)
                r_wr_bank <= !r_wr_bank;
            if (w_rd)
                r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_rd_done)
                r_rd_bank <= !r_rd_bank;
            if (in_valid && !in_ready)
                r_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_bitrev_streamer.sv
// tb_fft_bitrev_streamer: scoreboard bench for the bit-reversing ping-pong frame buffer
module tb_fft_bitrev_streamer;
    localparam int DW = 16;
    localparam int N  = 32;
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic          out_start;
    logic          out_last;
    logic          ovf;
    always #5 clk = ~clk;
    fft_bitrev_streamer #(.DATA_W(DW), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_start(out_start), .out_last(out_last), .ovf(ovf)
    );
    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        logic          st;
        logic          la;
    } exp_t;
    typedef struct {
        string name;
        int    frames;
        int    vin;
        int    ordy;
        logic  exp_ovf;
        int    exp_out;
    } vec_t;
    exp_t          exp_q[$];
    logic [DW-1:0] fr_r[N];
    logic [DW-1:0] fr_i[N];
    int            fr_cnt;
    int            nin;
    int            nout;
    bit            acc;
    int            checks = 0;
    int            failures = 0;
    vec_t          vecs[4];
    function automatic int brev(int k);
        int r = 0;
        for (int b = 0; b < 5; b++)
            if (k[b]) r |= 1 << (4 - b);
        return r;
    endfunction
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic clear_model();
        exp_q.delete();
        fr_cnt = 0;
        nin = 0;
        nout = 0;
    endtask
    // Sample at the falling edge, score handshakes, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_when_empty", out_valid, 1'b0);
            else begin
                e = exp_q.pop_front();
                chk("out_r", out_r, e.r);
                chk("out_i", out_i, e.i);
                chk("out_start", out_start, e.st);
                chk("out_last", out_last, e.la);
            end
            nout++;
        end
        if (!out_valid) chk("idle_zero", {out_start, out_last, out_r, out_i}, '0);
        if (in_valid && in_ready) begin
            acc = 1'b1;
            fr_r[fr_cnt] = in_r;
            fr_i[fr_cnt] = in_i;
            fr_cnt++;
            nin++;
            if (fr_cnt == N) begin
                for (int k = 0; k < N; k++)
                    exp_q.push_back({fr_r[brev(k)], fr_i[brev(k)], k == 0, k == N - 1});
                fr_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out", {out_valid, out_start, out_last, out_r, out_i}, '0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        clear_model();
    endtask
    task automatic drain(int budget);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) cycle();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_valid_low", out_valid, 1'b0);
    endtask
    task automatic run_stream(int frames, int vin, int ordy, int base);
        int s = 0;
        for (int c = 0; c < frames * N * 20 && s < frames * N; c++) begin
            in_r = DW'(base + s * 7);
            in_i = DW'(base ^ (s * 13));
            in_valid = in_ready && ($urandom_range(99) < vin);
            out_ready = $urandom_range(99) < ordy;
            cycle();
            if (acc) s++;
        end
        chk("stream_sent", s, frames * N);
        drain(frames * N * 20);
    endtask
    initial begin
        vecs[0] = '{"rand50",   20, 50,  50,  1'b0, 20 * N};
        vecs[1] = '{"in_slow",   3, 25,  90,  1'b0,  3 * N};
        vecs[2] = '{"out_slow",  3, 90,  25,  1'b0,  3 * N};
        vecs[3] = '{"full_rate", 2, 100, 100, 1'b0,  2 * N};
        in_r = '0;
        in_i = '0;
        clear_model();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_r = DW'(k);
            in_i = DW'(-k);
            cycle();
        end
        in_valid = 1'b0;
        chk("latency_start", {out_valid, out_start}, 2'b11);
        drain(40);
        chk("single_nout", nout, N);
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4 * N; k++) begin
            in_valid = 1'b1;
            in_r = DW'(3000 + k);
            in_i = DW'(k * 5);
            cycle();
            if (k == N - 1) chk("b2b_valid_after_f1", out_valid, 1'b1);
        end
        chk("b2b_accepts", nin, 4 * N);
        chk("b2b_out_mid", nout, 3 * N);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) cycle();
        chk("b2b_out_all", nout, 4 * N);
        chk("b2b_queue", exp_q.size(), 0);
        do_reset();
        for (int k = 0; k < 2 * N; k++) begin
            in_valid = 1'b1;
            in_r = DW'(1000 + k);
            in_i = DW'(~(1000 + k));
            cycle();
        end
        chk("bp_accepted", nin, 2 * N);
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_ovf_pre", ovf, 1'b0);
        in_r = DW'(1064);
        cycle();
        chk("bp_ovf", ovf, 1'b1);
        for (int k = 0; k < N - 1; k++) begin
            in_r = DW'(1065 + k);
            cycle();
        end
        chk("bp_no_accept", nin, 2 * N);
        drain(200);
        chk("bp_nout", nout, 2 * N);
        chk("bp_ovf_sticky", ovf, 1'b1);
        chk("bp_ready_back", in_ready, 1'b1);
        foreach (vecs[v]) begin
            do_reset();
            run_stream(vecs[v].frames, vecs[v].vin, vecs[v].ordy, 100 * v + 7);
            chk({vecs[v].name, "_nout"}, nout, vecs[v].exp_out);
            chk({vecs[v].name, "_ovf"}, ovf, vecs[v].exp_ovf);
        end
        do_reset();
        for (int k = 0; k < N + 6; k++) begin
            in_valid = 1'b1;
            in_r = DW'(k < N ? 1500 + k : 2000 + k);
            in_i = DW'(k);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_r = DW'(2100 + k);
            cycle();
        end
        chk("mid_nout", nout, 10);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_model();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_ovf", ovf, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_r = DW'(500 + k);
            in_i = DW'(700 - k);
            cycle();
        end
        drain(40);
        chk("mid_new_nout", nout, N);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
